// File: rtl/flag_unit.sv
// Execute-stage condition gating and architectural {N,Z,C,V} flags register,
// with a sticky illegal-condition flag and a saturating squash counter.
module flag_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        ValidE,
    input  logic [3:0]  CondE,
    input  logic [1:0]  FlagWriteE,
    input  logic [3:0]  ALUFlags,
    input  logic        CondEx,
    input  logic        RegWriteE,
    input  logic        MemWriteE,
    input  logic        PCSrcE,
    output logic [3:0]  Flags,
    output logic        RegWriteG,
    output logic        MemWriteG,
    output logic        PCSrcG,
    output logic        IllegalCond,
    output logic [15:0] SquashCount
);
    logic        active;
    logic        cond_legal;
    logic        cond_ok;
    logic        exec;

    logic [3:0]  flags_q;
    logic [3:0]  flags_d;
    logic        illegal_q;
    logic        illegal_d;
    logic [15:0] squash_q;
    logic [15:0] squash_d;

    always_comb begin
        active     = ValidE & ~Flush & ~Stall;
        cond_legal = (CondE <= 4'b0110);
        // An illegal code masks CondEx completely, so an unknown CondEx cannot leak through.
        cond_ok    = cond_legal & CondEx;
        exec       = active & cond_ok;
    end

    assign RegWriteG = RegWriteE & exec;
    assign MemWriteG = MemWriteE & exec;
    assign PCSrcG    = PCSrcE & exec;

    always_comb begin
        flags_d   = flags_q;
        illegal_d = illegal_q;
        squash_d  = squash_q;
        if (exec && FlagWriteE[1]) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (exec && FlagWriteE[0]) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
        if (active && !cond_legal) begin
            illegal_d = 1'b1;
        end
        if (active && !cond_ok && (squash_q != 16'hFFFF)) begin
            squash_d = squash_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q   <= 4'b0000;
            illegal_q <= 1'b0;
            squash_q  <= 16'd0;
        end else begin
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
            squash_q  <= squash_d;
        end
    end

    assign Flags       = flags_q;
    assign IllegalCond = illegal_q;
    assign SquashCount = squash_q;
endmodule

// File: tb/tb_flag_unit.sv
// Randomized and directed checks of flag_unit against a behavioural model of
// the flag, sticky-error and squash-count rules.
module tb_flag_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        Stall, Flush, ValidE, CondEx;
    logic [3:0]  CondE, ALUFlags;
    logic [1:0]  FlagWriteE;
    logic        RegWriteE, MemWriteE, PCSrcE;
    logic [3:0]  Flags;
    logic        RegWriteG, MemWriteG, PCSrcG, IllegalCond;
    logic [15:0] SquashCount;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [3:0] m_flags;
    bit         m_ill;
    int         m_cnt;

    always #5 clk = ~clk;

    flag_unit dut (
        .clk(clk), .rst_n(rst_n), .Stall(Stall), .Flush(Flush), .ValidE(ValidE),
        .CondE(CondE), .FlagWriteE(FlagWriteE), .ALUFlags(ALUFlags), .CondEx(CondEx),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE),
        .Flags(Flags), .RegWriteG(RegWriteG), .MemWriteG(MemWriteG), .PCSrcG(PCSrcG),
        .IllegalCond(IllegalCond), .SquashCount(SquashCount)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One Execute-stage transaction: drive at negedge, check, then advance the model at posedge.
    task automatic step(input bit st, input bit fl, input bit v, input logic [3:0] ce,
                        input logic [1:0] fw, input logic [3:0] alu, input bit cx,
                        input bit rw, input bit mw, input bit ps, input bit verbose);
        bit issue, legal, go;
        @(negedge clk);
        Stall = st; Flush = fl; ValidE = v; CondE = ce; FlagWriteE = fw;
        ALUFlags = alu; CondEx = cx; RegWriteE = rw; MemWriteE = mw; PCSrcE = ps;
        #1;
        issue = v && !fl && !st;
        legal = (int'(ce) <= 6);
        go    = issue && legal && cx;
        check_val("regwrite_g", {31'd0, RegWriteG}, {31'd0, rw && go});
        check_val("memwrite_g", {31'd0, MemWriteG}, {31'd0, mw && go});
        check_val("pcsrc_g",    {31'd0, PCSrcG},    {31'd0, ps && go});
        check_val("flags",      {28'd0, Flags},     {28'd0, m_flags});
        check_val("illegal",    {31'd0, IllegalCond}, {31'd0, m_ill});
        check_val("squash_cnt", {16'd0, SquashCount}, m_cnt);
        @(posedge clk);
        if (go && fw[1]) m_flags[3:2] = alu[3:2];
        if (go && fw[0]) m_flags[1:0] = alu[1:0];
        if (issue && !legal) m_ill = 1'b1;
        if (issue && !(legal && cx)) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
        if (verbose)
            $display("txn st=%0b fl=%0b v=%0b cond=%0h fw=%0b alu=%0b cx=%0b -> exec=%0b flags=%0b ill=%0b cnt=%0h",
                     st, fl, v, ce, fw, alu, cx, go, m_flags, m_ill, m_cnt);
    endtask

    initial begin
        rst_n = 1'b0;
        Stall = 0; Flush = 0; ValidE = 0; CondE = 0; FlagWriteE = 0; ALUFlags = 0;
        CondEx = 0; RegWriteE = 0; MemWriteE = 0; PCSrcE = 0;
        m_flags = 4'b0000; m_ill = 1'b0; m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_flags",   {28'd0, Flags}, 32'h0);
        check_val("rst_illegal", {31'd0, IllegalCond}, 32'h0);
        check_val("rst_count",   {16'd0, SquashCount}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // CMP setting Z, then an EQ branch sees it
        step(0, 0, 1, 4'h6, 2'b11, 4'b0100, 1, 0, 0, 0, 1);
        #1 check_val("cmp_flags", {28'd0, Flags}, 32'b0100);
        step(0, 0, 1, 4'h0, 2'b00, 4'b0000, 1, 0, 0, 1, 1);
        // N,Z-only write keeps C,V
        step(0, 0, 1, 4'h0, 2'b10, 4'b1011, 1, 1, 0, 0, 1);
        #1 check_val("nz_only", {28'd0, Flags}, 32'b1000);
        // Stall blocks everything
        step(1, 0, 1, 4'h0, 2'b11, 4'b0111, 1, 1, 1, 1, 1);
        // Flush beats stall
        step(1, 1, 1, 4'h7, 2'b11, 4'b0111, 1, 1, 1, 1, 1);
        #1 check_val("stall_flags", {28'd0, Flags}, 32'b1000);
        // Illegal condition with arbitrary CondEx
        step(0, 0, 1, 4'h9, 2'b11, 4'b1111, 1, 1, 1, 1, 1);
        #1 check_val("illegal_set", {31'd0, IllegalCond}, 32'h1);
        step(0, 0, 1, 4'h2, 2'b01, 4'b0011, 1, 0, 1, 0, 1);
        check_val("illegal_sticky", {31'd0, IllegalCond}, 32'h1);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 4) != 0,
                 4'($urandom_range(0, 9)), 2'($urandom), 4'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1);
        end

        // Drive the counter up to FFFE with condition-fail instructions
        while (m_cnt < 65534) step(0, 0, 1, 4'h1, 2'b11, 4'b1111, 0, 1, 1, 1, 0);
        #1 check_val("preload", {16'd0, SquashCount}, 32'hFFFE);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'h3, 2'b00, 4'b0000, 0, 1, 0, 0, 1);
        #1 check_val("saturate", {16'd0, SquashCount}, 32'hFFFF);
        step(0, 0, 1, 4'hC, 2'b00, 4'b0000, 0, 0, 0, 0, 1);
        #1 check_val("sat_hold", {16'd0, SquashCount}, 32'hFFFF);

        // Asynchronous reset mid-cycle after Flags = 1111
        step(0, 0, 1, 4'h0, 2'b11, 4'b1111, 1, 0, 0, 0, 1);
        @(negedge clk);
        ValidE = 1; Stall = 0; Flush = 0; CondE = 4'h0; CondEx = 1;
        RegWriteE = 1; MemWriteE = 0; PCSrcE = 1; FlagWriteE = 2'b00;
        #1 check_val("pre_rst_flags", {28'd0, Flags}, 32'b1111);
        #1 rst_n = 1'b0;
        #1;
        check_val("async_flags",   {28'd0, Flags}, 32'h0);
        check_val("async_illegal", {31'd0, IllegalCond}, 32'h0);
        check_val("async_count",   {16'd0, SquashCount}, 32'h0);
        check_val("rst_regwrite_g", {31'd0, RegWriteG}, 32'h1);
        check_val("rst_pcsrc_g",    {31'd0, PCSrcG}, 32'h1);
        m_flags = 4'b0000; m_ill = 1'b0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 1, 4'h5, 2'b01, 4'b0101, 1, 1, 1, 0, 1);
        step(0, 0, 1, 4'h5, 2'b00, 4'b0000, 0, 1, 1, 0, 1);
        #1 check_val("post_rst_cv", {28'd0, Flags}, 32'b0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
